// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: req/ack data-bus handshake, byte lanes, load extension, timeout.
// Optional misalignment check enabled by defining MEM_LSU_ALIGN_CHK_EN.
module mem_lsu #(
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 15,
  parameter bit          BIG_ENDIAN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic [31:0]           wdata_i,
  input  logic                  wreg_i,
  input  logic [3:0]            mem_op_i,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic [31:0]           mem_data_i,
  input  logic                  stall_i,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic [31:0]           wdata_o,
  output logic                  wreg_o,
  output logic                  stallreq_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [3:0]            mem_sel_o,
  output logic [31:0]           mem_wdata_o,
  input  logic                  mem_ack_i,
  input  logic [31:0]           mem_rdata_i,
  output logic                  bus_err_o,
  output logic                  align_err_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [7:0] CntLast = 8'(TIMEOUT_CYC - 1);

  logic [1:0]            state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [3:0]            op_q, op_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [31:0]           sdata_q, sdata_d;
  logic [REG_ADDR_W-1:0] wd_q, wd_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  wreg_q, wreg_d;

  logic [3:0]            cur_op;
  logic [ADDR_W-1:0]     cur_addr;
  logic [31:0]           cur_sdata;
  logic [REG_ADDR_W-1:0] cur_wd;
  logic [31:0]           cur_wdata;
  logic                  cur_wreg;
  logic                  is_load, is_store, is_byte, is_half, is_word, is_sign, misalign;
  logic [1:0]            boff, lane;
  logic                  half_hi;
  logic [7:0]            byte_v;
  logic [15:0]           half_v;
  logic [31:0]           ld_val, res_wdata;
  logic [3:0]            sel;
  logic [31:0]           wbus;

  // While waiting, the bus sees the captured request, not whatever EX presents.
  always_comb begin
    cur_op    = (state_q == StWait) ? op_q    : mem_op_i;
    cur_addr  = (state_q == StWait) ? addr_q  : mem_addr_i;
    cur_sdata = (state_q == StWait) ? sdata_q : mem_data_i;
    cur_wd    = (state_q == StWait) ? wd_q    : wd_i;
    cur_wdata = (state_q == StWait) ? wdata_q : wdata_i;
    cur_wreg  = (state_q == StWait) ? wreg_q  : wreg_i;

    is_load  = cur_op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    is_store = cur_op inside {4'd6, 4'd7, 4'd8};
    is_byte  = cur_op inside {4'd1, 4'd2, 4'd6};
    is_half  = cur_op inside {4'd3, 4'd4, 4'd7};
    is_word  = cur_op inside {4'd5, 4'd8};
    is_sign  = cur_op inside {4'd1, 4'd3};
    boff     = cur_addr[1:0];
`ifdef MEM_LSU_ALIGN_CHK_EN
    misalign = (state_q == StIdle) && ((is_half && boff[0]) || (is_word && (boff != 2'd0)));
`else
    misalign = 1'b0;
`endif

    lane    = BIG_ENDIAN ? (2'd3 - boff) : boff;
    half_hi = BIG_ENDIAN ? ~boff[1] : boff[1];
    byte_v  = 8'(mem_rdata_i >> {lane, 3'b000});
    half_v  = half_hi ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

    if (is_byte) begin
      sel    = 4'b0001 << lane;
      wbus   = {4{cur_sdata[7:0]}};
      ld_val = is_sign ? {{24{byte_v[7]}}, byte_v} : {24'd0, byte_v};
    end else if (is_half) begin
      sel    = half_hi ? 4'b1100 : 4'b0011;
      wbus   = {2{cur_sdata[15:0]}};
      ld_val = is_sign ? {{16{half_v[15]}}, half_v} : {16'd0, half_v};
    end else begin
      sel    = 4'b1111;
      wbus   = cur_sdata;
      ld_val = mem_rdata_i;
    end
    res_wdata = is_load ? ld_val : cur_wdata;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    sdata_d = sdata_q;
    wd_d    = wd_q;
    wdata_d = wdata_q;
    wreg_d  = wreg_q;

    wd_o        = cur_wd;
    wdata_o     = cur_wdata;
    wreg_o      = cur_wreg;
    stallreq_o  = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = is_store;
    mem_addr_o  = {cur_addr[ADDR_W-1:2], 2'b00};
    mem_sel_o   = sel;
    mem_wdata_o = wbus;
    bus_err_o   = 1'b0;
    align_err_o = misalign;

    unique case (state_q)
      StIdle: begin
        if (misalign) begin
          wreg_o = 1'b0;
        end else if (is_load || is_store) begin
          mem_req_o = 1'b1;
          wd_d      = wd_i;
          wreg_d    = wreg_i;
          if (mem_ack_i) begin
            wdata_o = res_wdata;
            wdata_d = res_wdata;
            state_d = stall_i ? StDone : StIdle;
          end else begin
            stallreq_o = 1'b1;
            wreg_o     = 1'b0;
            op_d       = mem_op_i;
            addr_d     = mem_addr_i;
            sdata_d    = mem_data_i;
            wdata_d    = wdata_i;
            cnt_d      = 8'd0;
            state_d    = StWait;
          end
        end
      end
      StWait: begin
        // The abort cycle carries no request, so a late ack there is meaningless.
        if (cnt_q == CntLast) begin
          bus_err_o = 1'b1;
          wreg_o    = 1'b0;
          wreg_d    = 1'b0;
          state_d   = stall_i ? StDone : StIdle;
        end else begin
          mem_req_o = 1'b1;
          if (mem_ack_i) begin
            wdata_o = res_wdata;
            wdata_d = res_wdata;
            state_d = stall_i ? StDone : StIdle;
          end else begin
            stallreq_o = 1'b1;
            wreg_o     = 1'b0;
            cnt_d      = cnt_q + 8'd1;
          end
        end
      end
      StDone: begin
        wd_o    = wd_q;
        wdata_o = wdata_q;
        wreg_o  = wreg_q;
        if (!stall_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (!mem_req_o) begin
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_sel_o   = 4'b0000;
      mem_wdata_o = 32'd0;
    end

    if (!rst) begin
      wd_o        = '0;
      wdata_o     = 32'd0;
      wreg_o      = 1'b0;
      stallreq_o  = 1'b0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_sel_o   = 4'b0000;
      mem_wdata_o = 32'd0;
      bus_err_o   = 1'b0;
      align_err_o = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      op_q    <= 4'd0;
      addr_q  <= '0;
      sdata_q <= 32'd0;
      wd_q    <= '0;
      wdata_q <= 32'd0;
      wreg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      sdata_q <= sdata_d;
      wd_q    <= wd_d;
      wdata_q <= wdata_d;
      wreg_q  <= wreg_d;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: single-cycle vector table plus wait, timeout, stall and reset sequences.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wd_i;
  logic [31:0] wdata_i;
  logic        wreg_i;
  logic [3:0]  mem_op_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic        stall_i;
  logic [4:0]  wd_o;
  logic [31:0] wdata_o;
  logic        wreg_o;
  logic        stallreq_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_sel_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        bus_err_o;
  logic        align_err_o;

  int checks = 0;
  int errors = 0;

  mem_lsu #(
    .REG_ADDR_W (5),
    .ADDR_W     (32),
    .TIMEOUT_CYC(15),
    .BIG_ENDIAN (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wd_i       (wd_i),
    .wdata_i    (wdata_i),
    .wreg_i     (wreg_i),
    .mem_op_i   (mem_op_i),
    .mem_addr_i (mem_addr_i),
    .mem_data_i (mem_data_i),
    .stall_i    (stall_i),
    .wd_o       (wd_o),
    .wdata_o    (wdata_o),
    .wreg_o     (wreg_o),
    .stallreq_o (stallreq_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_sel_o  (mem_sel_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_ack_i  (mem_ack_i),
    .mem_rdata_i(mem_rdata_i),
    .bus_err_o  (bus_err_o),
    .align_err_o(align_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic [4:0]  wd;
    logic [31:0] wdata;
    logic        wreg;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_addr;
    logic [3:0]  e_sel;
    logic [31:0] e_wbus;
    logic [31:0] e_wdata;
    logic        e_wreg;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [4:0] wd, input logic [31:0] wdata, input logic wreg,
                       input logic ack, input logic [31:0] rdata, input logic stall);
    mem_op_i    = op;
    mem_addr_i  = addr;
    mem_data_i  = sdata;
    wd_i        = wd;
    wdata_i     = wdata;
    wreg_i      = wreg;
    mem_ack_i   = ack;
    mem_rdata_i = rdata;
    stall_i     = stall;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int  reqs;
    bit  got;

    //        op    addr          sdata         rdata         wd     wdata         wr    req   we    e_addr        e_sel    e_wbus        e_wdata       e_wreg
    vecs[0]  = '{4'd0, 32'h0,       32'h0,        32'h0,        5'd3,  32'h1234,     1'b1, 1'b0, 1'b0, 32'h0,       4'b0000, 32'h0,        32'h1234,     1'b1};
    vecs[1]  = '{4'd1, 32'h101,     32'h0,        32'h11A23344, 5'd4,  32'h101,      1'b1, 1'b1, 1'b0, 32'h100,     4'b0100, 32'h0,        32'hFFFFFFA2, 1'b1};
    vecs[2]  = '{4'd2, 32'h101,     32'h0,        32'h11A23344, 5'd5,  32'h101,      1'b1, 1'b1, 1'b0, 32'h100,     4'b0100, 32'h0,        32'h000000A2, 1'b1};
    vecs[3]  = '{4'd7, 32'h202,     32'h0000BEEF, 32'h0,        5'd0,  32'h202,      1'b0, 1'b1, 1'b1, 32'h200,     4'b0011, 32'hBEEFBEEF, 32'h202,      1'b0};
    vecs[4]  = '{4'd3, 32'h200,     32'h0,        32'h80017F00, 5'd6,  32'h200,      1'b1, 1'b1, 1'b0, 32'h200,     4'b1100, 32'h0,        32'hFFFF8001, 1'b1};
    vecs[5]  = '{4'd4, 32'h202,     32'h0,        32'h80017F00, 5'd6,  32'h202,      1'b1, 1'b1, 1'b0, 32'h200,     4'b0011, 32'h0,        32'h00007F00, 1'b1};
    vecs[6]  = '{4'd5, 32'h304,     32'h0,        32'hDEADBEEF, 5'd7,  32'h304,      1'b1, 1'b1, 1'b0, 32'h304,     4'b1111, 32'h0,        32'hDEADBEEF, 1'b1};
    vecs[7]  = '{4'd6, 32'h403,     32'h12345678, 32'h0,        5'd8,  32'h403,      1'b1, 1'b1, 1'b1, 32'h400,     4'b0001, 32'h78787878, 32'h403,      1'b1};
    vecs[8]  = '{4'd8, 32'h500,     32'hCAFEF00D, 32'h0,        5'd2,  32'h500,      1'b0, 1'b1, 1'b1, 32'h500,     4'b1111, 32'hCAFEF00D, 32'h500,      1'b0};
    vecs[9]  = '{4'd9, 32'h600,     32'h0,        32'h0,        5'd9,  32'h55AA55AA, 1'b1, 1'b0, 1'b0, 32'h0,       4'b0000, 32'h0,        32'h55AA55AA, 1'b1};
    vecs[10] = '{4'd1, 32'h100,     32'h0,        32'h7F000000, 5'd10, 32'h100,      1'b1, 1'b1, 1'b0, 32'h100,     4'b1000, 32'h0,        32'h0000007F, 1'b1};
    vecs[11] = '{4'd1, 32'h103,     32'h0,        32'h00000080, 5'd11, 32'h103,      1'b1, 1'b1, 1'b0, 32'h100,     4'b0001, 32'h0,        32'hFFFFFF80, 1'b1};
    vecs[12] = '{4'd15, 32'h0,      32'h0,        32'h0,        5'd31, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 32'h0,       4'b0000, 32'h0,        32'hFFFFFFFF, 1'b0};

    // Reset: outputs forced to zero even with live inputs.
    rst = 1'b0;
    drive(4'd0, 32'h0, 32'h0, 5'd3, 32'h1234, 1'b1, 1'b0, 32'h0, 1'b0);
    #2;
    chk("rst_wd", 32'(wd_o), 32'd0);
    chk("rst_wdata", wdata_o, 32'd0);
    chk("rst_wreg", 32'(wreg_o), 32'd0);
    chk("rst_req", 32'(mem_req_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Single-cycle vectors: ack (when relevant) arrives in the issue cycle.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].addr, vecs[i].sdata, vecs[i].wd, vecs[i].wdata, vecs[i].wreg,
            vecs[i].e_req, vecs[i].rdata, 1'b0);
      #1;
      chk($sformatf("v%0d_req", i), 32'(mem_req_o), 32'(vecs[i].e_req));
      chk($sformatf("v%0d_stallreq", i), 32'(stallreq_o), 32'd0);
      chk($sformatf("v%0d_wd", i), 32'(wd_o), 32'(vecs[i].wd));
      chk($sformatf("v%0d_wdata", i), wdata_o, vecs[i].e_wdata);
      chk($sformatf("v%0d_wreg", i), 32'(wreg_o), 32'(vecs[i].e_wreg));
      if (vecs[i].e_req) begin
        chk($sformatf("v%0d_we", i), 32'(mem_we_o), 32'(vecs[i].e_we));
        chk($sformatf("v%0d_addr", i), mem_addr_o, vecs[i].e_addr);
        chk($sformatf("v%0d_sel", i), 32'(mem_sel_o), 32'(vecs[i].e_sel));
        chk($sformatf("v%0d_wbus", i), mem_wdata_o, vecs[i].e_wbus);
      end
    end

    // LB with ack two cycles late; request must stay stable while EX inputs wander.
    @(negedge clk);
    drive(4'd1, 32'h101, 32'h0, 5'd4, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    chk("lat_c0_req", 32'(mem_req_o), 32'd1);
    chk("lat_c0_stallreq", 32'(stallreq_o), 32'd1);
    chk("lat_c0_wreg", 32'(wreg_o), 32'd0);
    @(negedge clk);
    mem_addr_i = 32'h0;
    #1;
    chk("lat_c1_req", 32'(mem_req_o), 32'd1);
    chk("lat_c1_stallreq", 32'(stallreq_o), 32'd1);
    chk("lat_c1_sel", 32'(mem_sel_o), 32'b0100);
    chk("lat_c1_addr", mem_addr_o, 32'h100);
    @(negedge clk);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h11A23344;
    #1;
    chk("lat_c2_stallreq", 32'(stallreq_o), 32'd0);
    chk("lat_c2_wdata", wdata_o, 32'hFFFFFFA2);
    chk("lat_c2_wreg", 32'(wreg_o), 32'd1);
    chk("lat_c2_wd", 32'(wd_o), 32'd4);
    @(negedge clk);
    drive(4'd0, 32'h0, 32'h0, 5'd12, 32'hABCD, 1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    chk("lat_idle_req", 32'(mem_req_o), 32'd0);
    chk("lat_idle_wdata", wdata_o, 32'hABCD);

    // LW timeout: request high 15 cycles, then one bus_err cycle.
    @(negedge clk);
    drive(4'd5, 32'h600, 32'h0, 5'd5, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    reqs = 0;
    got  = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      #1;
      if (bus_err_o) begin
        got = 1'b1;
        chk("tout_wreg", 32'(wreg_o), 32'd0);
        chk("tout_stallreq", 32'(stallreq_o), 32'd0);
        chk("tout_req", 32'(mem_req_o), 32'd0);
      end else if (mem_req_o) begin
        reqs++;
      end
      if (!got) @(negedge clk);
    end
    chk("tout_seen", 32'(got), 32'd1);
    chk("tout_req_cycles", 32'(reqs), 32'd15);
    @(negedge clk);
    drive(4'd0, 32'h0, 32'h0, 5'd1, 32'h77, 1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    chk("tout_after_err", 32'(bus_err_o), 32'd0);
    chk("tout_after_req", 32'(mem_req_o), 32'd0);
    chk("tout_after_wdata", wdata_o, 32'h77);

    // LW acked under stall: DONE holds the result with no re-issue.
    @(negedge clk);
    drive(4'd5, 32'h700, 32'h0, 5'd13, 32'h700, 1'b1, 1'b1, 32'h13572468, 1'b1);
    #1;
    chk("stl_ack_req", 32'(mem_req_o), 32'd1);
    chk("stl_ack_stallreq", 32'(stallreq_o), 32'd0);
    chk("stl_ack_wdata", wdata_o, 32'h13572468);
    for (int d = 0; d < 3; d++) begin
      @(negedge clk);
      mem_ack_i   = 1'b0;
      mem_rdata_i = 32'h0;
      #1;
      chk($sformatf("stl_done%0d_req", d), 32'(mem_req_o), 32'd0);
      chk($sformatf("stl_done%0d_wdata", d), wdata_o, 32'h13572468);
      chk($sformatf("stl_done%0d_wreg", d), 32'(wreg_o), 32'd1);
    end
    @(negedge clk);
    stall_i = 1'b0;
    #1;
    chk("stl_release_req", 32'(mem_req_o), 32'd0);
    chk("stl_release_wdata", wdata_o, 32'h13572468);
    @(negedge clk);
    drive(4'd0, 32'h0, 32'h0, 5'd14, 32'h1111, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    chk("stl_idle_wdata", wdata_o, 32'h1111);
    chk("stl_idle_wd", 32'(wd_o), 32'd14);

    // Reset asserted mid-WAIT withdraws the request at once.
    @(negedge clk);
    drive(4'd5, 32'h800, 32'h0, 5'd15, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    #1;
    chk("rw_wait_req", 32'(mem_req_o), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("rw_req", 32'(mem_req_o), 32'd0);
    chk("rw_stallreq", 32'(stallreq_o), 32'd0);
    chk("rw_wdata", wdata_o, 32'd0);
    @(negedge clk);
    drive(4'd0, 32'h0, 32'h0, 5'd16, 32'h2222, 1'b1, 1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rw_idle_req", 32'(mem_req_o), 32'd0);
    chk("rw_idle_wdata", wdata_o, 32'h2222);

    @(negedge clk);
    drive(4'd5, 32'h3, 32'h0, 5'd17, 32'h3, 1'b1, 1'b1, 32'h0, 1'b0);
    #1;
`ifdef MEM_LSU_ALIGN_CHK_EN
    chk("al_err", 32'(align_err_o), 32'd1);
    chk("al_req", 32'(mem_req_o), 32'd0);
    chk("al_stallreq", 32'(stallreq_o), 32'd0);
    chk("al_wreg", 32'(wreg_o), 32'd0);
`else
    chk("al_err", 32'(align_err_o), 32'd0);
    chk("al_req", 32'(mem_req_o), 32'd1);
    chk("al_addr", mem_addr_o, 32'h0);
`endif
    @(negedge clk);
    drive(4'd0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Parametrised memory-access pipeline stage for the OpenMIPS-style core, sitting between the EX/MEM and MEM/WB registers.
- Non-memory ops pass wd/wdata/wreg through unchanged.
- Loads and stores run a req/ack handshake on the data bus, with byte-lane selection, load sign/zero extension, pipeline stall request and a bus timeout.

Parameters:
REG_ADDR_W, 5, register-file address width
ADDR_W, 32, data-bus address width
TIMEOUT_CYC, 15, WAIT cycles without ack before abort (1..255)
BIG_ENDIAN, 1, 1 = MIPS big-endian lanes (byte 0 at [31:24]); 0 = little-endian

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
wd_i  in  REG_ADDR_W  destination register from EX
wdata_i  in  32  ALU result from EX
wreg_i  in  1  write-enable from EX
mem_op_i  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as NONE
mem_addr_i  in  ADDR_W  effective address
mem_data_i  in  32  store data (rt)
stall_i  in  1  downstream/global stall; MEM/WB holds this cycle
wd_o  out  REG_ADDR_W  to MEM/WB
wdata_o  out  32  to MEM/WB
wreg_o  out  1  to MEM/WB
stallreq_o  out  1  stall request to pipeline control
mem_req_o  out  1  bus request
mem_we_o  out  1  1 = write
mem_addr_o  out  ADDR_W  word-aligned address (low 2 bits 0)
mem_sel_o  out  4  byte enables
mem_wdata_o  out  32  store data replicated across lanes
mem_ack_i  in  1  bus completion
mem_rdata_i  in  32  bus read data
bus_err_o  out  1  one-cycle pulse on timeout
align_err_o  out  1  misalignment flag (optional feature)

Behaviour:
- Reset (rst=0, async): state=IDLE, timeout counter=0, captured data=0. While rst=0 all outputs are 0; wd_o=0, wdata_o=0.
- FSM states: IDLE, WAIT, DONE.
- IDLE, mem_op NONE: outputs = inputs combinationally; mem_req_o=0; stallreq_o=0.
- IDLE, mem op: mem_req_o=1 in the same cycle.
  - mem_ack_i=1 same cycle: op completes with zero extra latency and stallreq_o=0. Next state is DONE if stall_i=1, else IDLE.
  - No ack: stallreq_o=1, next state WAIT, counter=0.
- WAIT: mem_req_o and all bus outputs held stable; stallreq_o=1; counter increments each cycle.
  - ack: complete as above and capture load data. Next state DONE if stall_i=1, else IDLE.
  - Counter reaches TIMEOUT_CYC-1 with no ack: mem_req_o drops and bus_err_o pulses for 1 cycle. wreg_o=0 and stallreq_o=0 that cycle. Next state DONE if stall_i=1, else IDLE.
- DONE: mem_req_o=0; stallreq_o=0; outputs driven from the captured result.
  - Returns to IDLE on the first edge with stall_i=0.
  - The same instruction is never re-issued.
- Lane mapping (BIG_ENDIAN=1; little-endian mirrors it):
  - Byte: addr[1:0]=0..3 gives sel 1000/0100/0010/0001.
  - Half: addr[1]=0 gives 1100, addr[1]=1 gives 0011.
  - Word: 1111.
- Store data: byte replicated x4, halfword x2.
- Loads: selected lane is extended to 32 bits. LB/LH sign-extend; LBU/LHU zero-extend.
- Stores: wreg_o=wreg_i; wdata_o=wdata_i.
- wreg_o=0 whenever stallreq_o=1.
- Reset mid-WAIT: request withdrawn immediately and state returns to IDLE. The bus slave must tolerate the abandoned request.

Optional Feature:
MEM_LSU_ALIGN_CHK_EN
- Defined: misaligned access (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) issues no request. align_err_o=1 combinationally, wreg_o=0, stallreq_o=0, and the stage completes like NONE.
- Undefined: align_err_o tied 0. Offending low address bits are ignored (halfword uses addr[1], word forced aligned).

Test Plan:
1. mem_op=NONE, wd_i=3, wdata_i=0x1234, wreg_i=1 -> same-cycle outputs 3/0x1234/1, mem_req_o=0, stallreq_o=0.
2. LB addr=0x101, ack after 2 cycles with rdata=0x11A23344 -> sel=0100, stallreq_o high 2 cycles, wdata_o=0xFFFFFFA2. LBU of the same access -> 0x000000A2.
3. SH addr=0x202, data=0xBEEF, same-cycle ack -> mem_we_o=1, sel=0011, wdata=0xBEEFBEEF, addr_o=0x200, stallreq_o=0.
4. LW, no ack, TIMEOUT_CYC=15 -> req high 15 cycles, bus_err_o pulses once, wreg_o=0, state returns to IDLE.
5. LW ack while stall_i=1 for 3 more cycles -> DONE holds rdata, req=0, no re-issue; IDLE after stall_i falls.
6. rst pulsed low mid-WAIT -> mem_req_o=0 immediately. With MEM_LSU_ALIGN_CHK_EN, LW addr=0x3 -> align_err_o=1, no request.
